update_knn_mul_arbiter: RTL and testbench
=========================================

# update_knn_mul_arbiter

Round-robin arbiter that shares one pipelined unsigned multiplier (15-bit × 17-bit → 31-bit, 4-cycle latency, clock-enable stall) among NUM_REQ requesters in the KNN update datapath. It registers the granted operands, tracks each in-flight product with a requester tag, and returns each result to its owner. When the owner is not ready at the pipeline head, the block stalls the multiplier through its clock enable. It sits between the distance/update engines and the multiplier instance.

## Interface
- NUM_REQ, 4, number of requesters (2..8)
- A_WIDTH, 15, operand A width
- B_WIDTH, 17, operand B width
- P_WIDTH, 31, product width: low P_WIDTH bits of A×B
- LATENCY, 4, grant edge to result-valid, in enabled cycles. Comprises 1 arbiter operand register plus 3 multiplier stages.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-low reset (0 = reset)
- req_valid  in  NUM_REQ  per-requester operation request
- req_ready  out  NUM_REQ  per-requester accept; one-hot or zero
- req_a  in  NUM_REQ*A_WIDTH  packed operand A; requester i at [i*A_WIDTH +: A_WIDTH]
- req_b  in  NUM_REQ*B_WIDTH  packed operand B
- rsp_valid  out  NUM_REQ  one-hot result valid
- rsp_ready  in  NUM_REQ  per-requester result accept
- rsp_p  out  P_WIDTH  result; shared by all requesters, qualified by rsp_valid
- mul_ce  out  1  multiplier clock enable
- mul_din0  out  A_WIDTH  registered operand A to multiplier
- mul_din1  out  B_WIDTH  registered operand B to multiplier
- mul_dout  in  P_WIDTH  multiplier product
- stat_clr  in  1  clears grant counters (only with UPDATE_KNN_MUL_ARB_STATS_EN)
- stat_grants  out  NUM_REQ*16  per-requester grant counts (only with UPDATE_KNN_MUL_ARB_STATS_EN)

## Operation
- Tag pipeline: LATENCY stages. Each stage holds a valid bit and a requester id of ceil(log2 NUM_REQ) bits. Stage 0 loads on grant; stage LATENCY-1 is the head.
- Stall rule: stall = head_valid & ~rsp_ready[head_id]; mul_ce = ~stall.
- While stalled, all of the following freeze: tag stages, mul_din0/1, multiplier, and the round-robin pointer.
- Arbitration (only when mul_ce = 1): grant the first requester with req_valid = 1, searching from rr_ptr upward, modulo NUM_REQ.
  - req_ready[g] = 1 for the granted requester only, in the same cycle (combinational).
  - After a grant to g, rr_ptr <= (g+1) mod NUM_REQ.
  - With no request, rr_ptr holds and stage 0 loads valid = 0.
- On a handshake (req_valid[g] & req_ready[g]): mul_din0/1 <= req_a/req_b slice g, and stage 0 <= {1, g}. With no grant, mul_din0/1 hold their value.
- Response: rsp_valid[i] = head_valid & (head_id == i); rsp_p = mul_dout (combinational passthrough).
- Result and issue in the same cycle: a result retires and a new request is accepted together; the pipeline shifts with no bubble.
- Throughput: one operation per cycle while there is no stall.
- Arithmetic: unsigned. Results are the low P_WIDTH bits of the 32-bit product, so the MSB is dropped.

## Timing
- Reset values (reset = 0 at a rising edge):
  - req_ready = 0, rsp_valid = 0, mul_ce = 1
  - mul_din0/1 = 0, all tag valids = 0, rr_ptr = 0
  - stat_grants = 0
- Latency: a request accepted at edge t shows rsp_valid at edge t+LATENCY, plus the number of stalled cycles in between.
- Reset asserted mid-operation discards every in-flight tag; rsp_valid is 0 after that edge. Products still inside the multiplier are ignored because their tags are invalid.
- A stall lasts exactly as long as the head owner holds rsp_ready = 0. There is no timeout.
- req_ready depends combinationally on req_valid, rsp_ready and the head tag. Requesters must not make req_valid depend on req_ready.

## Configuration
- UPDATE_KNN_MUL_ARB_STATS_EN defined:
  - One 16-bit saturating grant counter per requester, incremented on each handshake.
  - stat_clr = 1 zeroes all counters on the next edge, with priority over increment.
  - Counters reset to 0.
- UPDATE_KNN_MUL_ARB_STATS_EN undefined: stat_clr and stat_grants ports and their counters are absent. All other behaviour is identical.

## Test plan
- Single op: requester 2 sends a=100, b=200 at edge 5, rsp_ready all 1 → rsp_valid = 4'b0100 and rsp_p = 20000 at edge 9; no other rsp_valid.
- Truncation: a=32767, b=131071 → rsp_p = 2147319809 (low 31 bits of 4294803457).
- Round-robin: all four req_valid held high for 8 cycles → grant order 0,1,2,3,0,1,2,3; results return in the same order, one per cycle, each tagged correctly.
- Backpressure: continuous traffic, rsp_ready[1] = 0 for 3 cycles while the head is owned by 1 → mul_ce = 0, req_ready = 0 and rsp_valid[1] held for 3 cycles; after release, all results delivered in order, none lost or duplicated.
- Reset mid-flight: 3 ops in flight, reset = 0 for one edge → rsp_valid = 0 for the next 4 cycles, rr_ptr = 0 (requester 0 granted first on the next contention).
- Stats (macro defined): 70000 grants to requester 0 → stat_grants[0] = 65535; pulse stat_clr → 0.

Source files
------------

// File: rtl/update_knn_mul_arbiter.sv
// Round-robin arbiter sharing one pipelined unsigned multiplier among
// NUM_REQ requesters. It registers the granted operands and tracks each
// in-flight product with a requester tag. Each result is steered back to
// the requester that issued it. When the owner of the head result is not
// ready, the arbiter stalls the whole pipe through mul_ce.
//
// Optional feature: define UPDATE_KNN_MUL_ARB_STATS_EN to add per-requester
// 16-bit saturating grant counters (stat_clr / stat_grants ports).
module update_knn_mul_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int A_WIDTH = 15,
  parameter int B_WIDTH = 17,
  parameter int P_WIDTH = 31,
  parameter int LATENCY = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_REQ-1:0]           req_valid,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic [NUM_REQ*A_WIDTH-1:0]   req_a,
  input  logic [NUM_REQ*B_WIDTH-1:0]   req_b,
  output logic [NUM_REQ-1:0]           rsp_valid,
  input  logic [NUM_REQ-1:0]           rsp_ready,
  output logic [P_WIDTH-1:0]           rsp_p,
  output logic                         mul_ce,
  output logic [A_WIDTH-1:0]           mul_din0,
  output logic [B_WIDTH-1:0]           mul_din1,
`ifdef UPDATE_KNN_MUL_ARB_STATS_EN
  input  logic                         stat_clr,
  output logic [NUM_REQ*16-1:0]        stat_grants,
`endif
  input  logic [P_WIDTH-1:0]           mul_dout
);

  localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  // Tag pipeline: index 0 loads on grant, index LATENCY-1 is the head.
  logic [LATENCY-1:0]           tag_valid;
  logic [LATENCY-1:0][ID_W-1:0] tag_id;

  logic            head_valid;
  logic [ID_W-1:0] head_id;
  logic            head_ready;
  logic            stall;

  logic               gnt_any;
  logic [ID_W-1:0]    gnt_id;
  logic [A_WIDTH-1:0] gnt_a;
  logic [B_WIDTH-1:0] gnt_b;
  logic [ID_W-1:0]    rr_ptr;
  logic [ID_W-1:0]    rr_next;
  int                 best_dist;
  int                 cur_dist;

  assign head_valid = tag_valid[LATENCY-1];
  assign head_id    = tag_id[LATENCY-1];

  // Look up the head owner's rsp_ready without indexing past NUM_REQ.
  always_comb begin
    head_ready = 1'b1;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (head_id == ID_W'(i)) head_ready = rsp_ready[i];
    end
  end

  assign stall  = head_valid & ~head_ready;
  assign mul_ce = ~stall;

  // Round-robin search: choose the valid requester nearest to rr_ptr going
  // upward with wrap-around. Arbitration is suppressed while stalled or in reset.
  always_comb begin
    gnt_any   = 1'b0;
    gnt_id    = '0;
    gnt_a     = '0;
    gnt_b     = '0;
    best_dist = NUM_REQ;
    cur_dist  = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cur_dist = (i >= int'(rr_ptr)) ? (i - int'(rr_ptr)) : (i + NUM_REQ - int'(rr_ptr));
      if (req_valid[i] && (cur_dist < best_dist)) begin
        best_dist = cur_dist;
        gnt_any   = 1'b1;
        gnt_id    = ID_W'(i);
        gnt_a     = req_a[i*A_WIDTH +: A_WIDTH];
        gnt_b     = req_b[i*B_WIDTH +: B_WIDTH];
      end
    end
    if (stall || !reset) gnt_any = 1'b0;
  end

  assign rr_next = (gnt_id == ID_W'(NUM_REQ - 1)) ? '0 : gnt_id + ID_W'(1);

  // Per-requester handshake and response steering from the head tag.
  always_comb begin
    req_ready = '0;
    rsp_valid = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_ready[i] = gnt_any && (gnt_id == ID_W'(i));
      rsp_valid[i] = head_valid && (head_id == ID_W'(i));
    end
  end

  assign rsp_p = mul_dout;

  // Advance tags, operands and pointer together; everything freezes on stall.
  always_ff @(posedge clk) begin
    if (!reset) begin
      tag_valid <= '0;
      tag_id    <= '0;
      rr_ptr    <= '0;
      mul_din0  <= '0;
      mul_din1  <= '0;
    end else if (!stall) begin
      tag_valid <= {tag_valid[LATENCY-2:0], gnt_any};
      tag_id    <= {tag_id[LATENCY-2:0], gnt_id};
      if (gnt_any) begin
        rr_ptr   <= rr_next;
        mul_din0 <= gnt_a;
        mul_din1 <= gnt_b;
      end
    end
  end

`ifdef UPDATE_KNN_MUL_ARB_STATS_EN
  logic [NUM_REQ-1:0][15:0] grant_cnt;

  // Saturating grant counters; clear wins over increment.
  always_ff @(posedge clk) begin
    if (!reset || stat_clr) begin
      grant_cnt <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (req_valid[i] && req_ready[i] && (grant_cnt[i] != 16'hFFFF))
          grant_cnt[i] <= grant_cnt[i] + 16'd1;
      end
    end
  end

  assign stat_grants = grant_cnt;
`endif

endmodule

// File: tb/tb_update_knn_mul_arbiter.sv
// Self-checking bench for update_knn_mul_arbiter. The bench models the
// external 3-stage multiplier. An in-order queue model predicts the outputs
// every cycle. Directed scenarios pin key values with literals.
// Build with UPDATE_KNN_MUL_ARB_STATS_EN defined to also cover the counters.
module tb_update_knn_mul_arbiter;
  localparam int N  = 4;
  localparam int AW = 15;
  localparam int BW = 17;
  localparam int PW = 31;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N*AW-1:0] req_a;
  logic [N*BW-1:0] req_b;
  logic [N-1:0]    rsp_valid;
  logic [N-1:0]    rsp_ready;
  logic [PW-1:0]   rsp_p;
  logic            mul_ce;
  logic [AW-1:0]   mul_din0;
  logic [BW-1:0]   mul_din1;
  logic [PW-1:0]   mul_dout;
`ifdef UPDATE_KNN_MUL_ARB_STATS_EN
  logic            stat_clr;
  logic [N*16-1:0] stat_grants;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  update_knn_mul_arbiter dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_p(rsp_p),
    .mul_ce(mul_ce), .mul_din0(mul_din0), .mul_din1(mul_din1),
`ifdef UPDATE_KNN_MUL_ARB_STATS_EN
    .stat_clr(stat_clr), .stat_grants(stat_grants),
`endif
    .mul_dout(mul_dout)
  );

  always #5 clk = ~clk;

  // External multiplier: 3 enabled stages after the operand register.
  logic [63:0] m1 = '0, m2 = '0, m3 = '0;
  always @(posedge clk) begin
    if (mul_ce) begin
      m1 <= 64'(mul_din0) * 64'(mul_din1);
      m2 <= m1;
      m3 <= m2;
    end
  end
  assign mul_dout = m3[PW-1:0];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: in-order list of outstanding operations with enabled-edge age.
  int          q_id[$];
  logic [63:0] q_p[$];
  int          q_age[$];
  int          m_rr = 0;
  logic [AW-1:0] m_din0 = '0;
  logic [BW-1:0] m_din1 = '0;
  int          m_cnt[N];

  logic          e_head, e_ce, e_gnt_any;
  int            e_hid, e_gnt;
  logic [N-1:0]  e_req_ready, e_rsp_valid;
  logic [63:0]   e_rsp_p;

  task automatic model_eval();
    int j;
    e_head = 1'b0;
    if (q_id.size() > 0) e_head = (q_age[0] == 3);
    e_hid = e_head ? q_id[0] : 0;
    e_ce = !(e_head && !rsp_ready[e_hid]);
    e_gnt_any = 1'b0;
    e_gnt = 0;
    if (e_ce && reset === 1'b1) begin
      for (int k = 0; k < N; k++) begin
        j = (m_rr + k) % N;
        if (!e_gnt_any && req_valid[j]) begin
          e_gnt_any = 1'b1;
          e_gnt = j;
        end
      end
    end
    e_req_ready = e_gnt_any ? (N'(1) << e_gnt) : '0;
    e_rsp_valid = e_head ? (N'(1) << e_hid) : '0;
    e_rsp_p = e_head ? q_p[0] : 64'd0;
  endtask

  // Advance the model on every edge using the inputs just sampled.
  always @(posedge clk) begin
    logic [63:0] full;
    model_eval();
    if (reset !== 1'b1) begin
      q_id.delete(); q_p.delete(); q_age.delete();
      m_rr = 0; m_din0 = '0; m_din1 = '0;
    end else if (e_ce) begin
      if (e_head) begin
        void'(q_id.pop_front()); void'(q_p.pop_front()); void'(q_age.pop_front());
      end
      foreach (q_age[i]) q_age[i]++;
      if (e_gnt_any) begin
        m_din0 = req_a[e_gnt*AW +: AW];
        m_din1 = req_b[e_gnt*BW +: BW];
        full = 64'(m_din0) * 64'(m_din1);
        q_id.push_back(e_gnt);
        q_p.push_back({33'd0, full[PW-1:0]});
        q_age.push_back(0);
        m_rr = (e_gnt + 1) % N;
      end
    end
`ifdef UPDATE_KNN_MUL_ARB_STATS_EN
    for (int i = 0; i < N; i++) begin
      if (reset !== 1'b1 || stat_clr) m_cnt[i] = 0;
      else if (e_gnt_any && e_gnt == i && m_cnt[i] < 65535) m_cnt[i]++;
    end
`endif
  end

  // Logs of observed grants and delivered results, for order checks.
  int gnt_log[$];
  int rsp_log[$];

  // Per-cycle compare against the model, away from the active edge.
  always @(negedge clk) begin
    model_eval();
    chk("req_ready", 64'(req_ready), 64'(e_req_ready));
    chk("rsp_valid", 64'(rsp_valid), 64'(e_rsp_valid));
    chk("mul_ce", 64'(mul_ce), 64'(e_ce));
    chk("mul_din0", 64'(mul_din0), 64'(m_din0));
    chk("mul_din1", 64'(mul_din1), 64'(m_din1));
    if (e_head) chk("rsp_p", 64'(rsp_p), e_rsp_p);
`ifdef UPDATE_KNN_MUL_ARB_STATS_EN
    for (int i = 0; i < N; i++)
      chk("stat_grants", 64'(stat_grants[i*16 +: 16]), 64'(m_cnt[i]));
`endif
    for (int i = 0; i < N; i++) begin
      if (req_valid[i] && req_ready[i]) gnt_log.push_back(i);
      if (rsp_valid[i] && rsp_ready[i]) rsp_log.push_back(i);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int r, input int a, input int b);
    req_a[r*AW +: AW] = AW'(a);
    req_b[r*BW +: BW] = BW'(b);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick();
    reset = 1'b1;
  endtask

  // Single op from requester r with literal latency and product checks.
  task automatic single_op(input int r, input int a, input int b, input logic [63:0] exp_p, input string nm);
    req_valid = '0;
    req_valid[r] = 1'b1;
    set_op(r, a, b);
    #1;
    chk({nm, "_grant"}, 64'(req_ready), 64'(N'(1) << r));
    tick();
    req_valid = '0;
    tick();
    chk({nm, "_early1"}, 64'(rsp_valid), 64'd0);
    tick();
    chk({nm, "_early2"}, 64'(rsp_valid), 64'd0);
    tick();
    chk({nm, "_valid"}, 64'(rsp_valid), 64'(N'(1) << r));
    chk({nm, "_p"}, 64'(rsp_p), exp_p);
    tick();
    chk({nm, "_after"}, 64'(rsp_valid), 64'd0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int found;
    reset = 1'b0;
    req_valid = '0;
    req_a = '0;
    req_b = '0;
    rsp_ready = '1;
`ifdef UPDATE_KNN_MUL_ARB_STATS_EN
    stat_clr = 1'b0;
`endif
    tick();
    tick();
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_mul_ce", 64'(mul_ce), 64'd1);
    chk("rst_din0", 64'(mul_din0), 64'd0);
    chk("rst_din1", 64'(mul_din1), 64'd0);
    reset = 1'b1;
    tick();

    single_op(2, 100, 200, 64'd20000, "single");
    single_op(1, 32767, 131071, 64'd2147319809, "trunc");

    // Round-robin with all requesters active for 8 cycles.
    do_reset();
    gnt_log.delete();
    rsp_log.delete();
    for (int c = 0; c < 8; c++) begin
      for (int r = 0; r < N; r++) set_op(r, 10 * r + c + 1, 1000 + 7 * c);
      req_valid = '1;
      tick();
    end
    req_valid = '0;
    for (int c = 0; c < 6; c++) tick();
    chk("rr_gnt_count", 64'(gnt_log.size()), 64'd8);
    chk("rr_rsp_count", 64'(rsp_log.size()), 64'd8);
    for (int i = 0; i < 8; i++) begin
      if (i < gnt_log.size()) chk("rr_gnt_order", 64'(gnt_log[i]), 64'(i % 4));
      if (i < rsp_log.size()) chk("rr_rsp_order", 64'(rsp_log[i]), 64'(i % 4));
    end

    // Backpressure: hold requester 1 off while it owns the head.
    gnt_log.delete();
    rsp_log.delete();
    for (int r = 0; r < N; r++) set_op(r, 300 + r, 5000 + 3 * r);
    req_valid = '1;
    found = 0;
    for (int c = 0; c < 20 && !found; c++) begin
      tick();
      if (rsp_valid[1]) found = 1;
    end
    chk("bp_head_found", 64'(found), 64'd1);
    rsp_ready = 4'b1101;
    #1;
    for (int c = 0; c < 3; c++) begin
      chk("bp_mul_ce", 64'(mul_ce), 64'd0);
      chk("bp_req_ready", 64'(req_ready), 64'd0);
      chk("bp_rsp_valid1", 64'(rsp_valid), 64'b0010);
      tick();
    end
    rsp_ready = '1;
    #1;
    chk("bp_release_ce", 64'(mul_ce), 64'd1);
    for (int c = 0; c < 4; c++) tick();
    req_valid = '0;
    for (int c = 0; c < 8; c++) tick();
    chk("bp_delivered", 64'(rsp_log.size()), 64'(gnt_log.size()));
    for (int i = 0; i < gnt_log.size() && i < rsp_log.size(); i++)
      chk("bp_order", 64'(rsp_log[i]), 64'(gnt_log[i]));

    // Reset with three operations in flight.
    for (int r = 3; r >= 1; r--) begin
      req_valid = '0;
      req_valid[r] = 1'b1;
      set_op(r, 40 + r, 50 + r);
      tick();
    end
    req_valid = '0;
    do_reset();
    for (int c = 0; c < 4; c++) begin
      chk("rst_flight_rsp", 64'(rsp_valid), 64'd0);
      tick();
    end
    req_valid = '1;
    #1;
    chk("rst_rr_ptr", 64'(req_ready), 64'b0001);
    tick();
    req_valid = '0;
    for (int c = 0; c < 6; c++) tick();

`ifdef UPDATE_KNN_MUL_ARB_STATS_EN
    // Saturation after 70000 grants to requester 0, then clear.
    do_reset();
    set_op(0, 3, 5);
    req_valid = 4'b0001;
    for (int c = 0; c < 70000; c++) tick();
    req_valid = '0;
    chk("stat_sat", 64'(stat_grants[15:0]), 64'd65535);
    stat_clr = 1'b1;
    tick();
    stat_clr = 1'b0;
    chk("stat_clr", 64'(stat_grants[15:0]), 64'd0);
    for (int c = 0; c < 6; c++) tick();
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
